global_buffer: RTL and testbench

Single-port-per-direction on-chip global buffer implementing the buffer side of the global buffer data interface and the controllee side of the control interface. It decodes `global_buffer_instruction_t` commands, accepts streamed write words into an internal word-addressed memory, and streams activation words back out with a valid strobe. It sits between the DMA/host loader and the PE-array feeder.

---
 rtl/global_buffer_if.sv | 36 +++
 rtl/global_buffer.sv | 140 ++++++++++++++
 tb/tb_global_buffer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/global_buffer_if.sv
// Data and control bundle between the global buffer and its loader/feeder.
// The master drives opcodes and write words; the slave (buffer) returns read words and status.
interface global_buffer_if #(
    parameter int unsigned dataSize       = 8,
    parameter int unsigned interfaceDepth = 16,
    parameter int unsigned addrWidth      = 32,
    parameter int unsigned bufferDepth    = 256
);
    localparam int unsigned interfaceWidth = interfaceDepth * dataSize;
    localparam int unsigned ptrWidth       = $clog2(bufferDepth);

    logic [3:0]                instr;
    logic                      instr_valid;
    logic                      instr_ready;
    logic [addrWidth-1:0]      weight_start_addr;
    logic [addrWidth-1:0]      activation_start_addr;
    logic [ptrWidth:0]         read_count;
    logic [interfaceWidth-1:0] wr_data;
    logic                      wr_en;
    logic [interfaceWidth-1:0] rd_data;
    logic                      rd_data_valid;
    logic                      done;
    logic                      wr_drop;

    modport master (
        output instr, instr_valid, weight_start_addr, activation_start_addr,
               read_count, wr_data, wr_en,
        input  instr_ready, rd_data, rd_data_valid, done, wr_drop
    );

    modport slave (
        input  instr, instr_valid, weight_start_addr, activation_start_addr,
               read_count, wr_data, wr_en,
        output instr_ready, rd_data, rd_data_valid, done, wr_drop
    );
endinterface

// File: rtl/global_buffer.sv
// Word-addressed on-chip global buffer: decodes load/read opcodes, absorbs streamed
// write words and streams activation words back with a one-cycle read latency.
module global_buffer #(
    parameter int unsigned dataSize       = 8,
    parameter int unsigned interfaceDepth = 16,
    parameter int unsigned addrWidth      = 32,
    parameter int unsigned bufferDepth    = 256
) (
    input logic           clk,
    input logic           rst,
    global_buffer_if.slave bus
);
    localparam int unsigned interfaceWidth = interfaceDepth * dataSize;
    localparam int unsigned ptrWidth       = $clog2(bufferDepth);

    typedef enum logic [3:0] {
        I_NOP             = 4'd0,
        I_POINTER_RESET   = 4'd1,
        I_LOAD_WEIGHT     = 4'd2,
        I_LOAD_ACTIVATION = 4'd3,
        I_LOAD_OUTPUT     = 4'd4,
        I_READ_ACTIVATION = 4'd5
    } global_buffer_instruction_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    logic [interfaceWidth-1:0] mem [bufferDepth];

    state_t                    state;
    logic [ptrWidth-1:0]       wr_ptr;
    logic [ptrWidth-1:0]       rd_ptr;
    logic [ptrWidth:0]         remaining;
    logic [interfaceWidth-1:0] rd_data_q;
    logic                      rd_data_valid_q;
    logic                      done_q;
    logic                      wr_drop_q;
    logic                      instr_ready_q;
    logic                      accept;
    logic                      write_fire;
    logic                      unused_addr_bits;

    assign bus.instr_ready   = instr_ready_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.done          = done_q;
    assign bus.wr_drop       = wr_drop_q;

    assign accept     = bus.instr_valid && instr_ready_q;
    assign write_fire = (state == S_WRITE) && bus.wr_en;

    // Start addresses wrap into the buffer; upper bits carry no meaning here.
    assign unused_addr_bits = ^{bus.weight_start_addr[addrWidth-1:ptrWidth],
                                bus.activation_start_addr[addrWidth-1:ptrWidth]};

    always_ff @(posedge clk) begin
        if (write_fire) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Control FSM; instr_ready is registered alongside the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            remaining       <= '0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
            done_q          <= 1'b0;
            wr_drop_q       <= 1'b0;
            instr_ready_q   <= 1'b1;
        end else begin
            rd_data_valid_q <= 1'b0;
            done_q          <= 1'b0;
            wr_drop_q       <= bus.wr_en && (state != S_WRITE);

            if (write_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case (state)
                S_READ: begin
                    rd_data_q       <= mem[rd_ptr];
                    rd_data_valid_q <= 1'b1;
                    rd_ptr          <= rd_ptr + 1'b1;
                    remaining       <= remaining - 1'b1;
                    if (remaining == (ptrWidth+1)'(1)) begin
                        state  <= S_DRAIN;
                        done_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    state         <= S_IDLE;
                    instr_ready_q <= 1'b1;
                end
                default: ;
            endcase

            // Accept only happens in IDLE/WRITE, so it never collides with the READ/DRAIN arms.
            if (accept) begin
                case (bus.instr)
                    I_POINTER_RESET: begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        state  <= S_IDLE;
                    end
                    I_LOAD_WEIGHT: begin
                        wr_ptr <= bus.weight_start_addr[ptrWidth-1:0];
                        state  <= S_WRITE;
                    end
                    I_LOAD_ACTIVATION: begin
                        wr_ptr <= bus.activation_start_addr[ptrWidth-1:0];
                        state  <= S_WRITE;
                    end
                    I_LOAD_OUTPUT: begin
                        state <= S_WRITE;
                    end
                    I_READ_ACTIVATION: begin
                        rd_ptr    <= bus.activation_start_addr[ptrWidth-1:0];
                        remaining <= bus.read_count;
                        if (bus.read_count != '0) begin
                            state         <= S_READ;
                            instr_ready_q <= 1'b0;
                        end else begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_global_buffer.sv
// Directed self-checking bench for global_buffer: load/read streams, wrap, append,
// dropped writes, zero-length read and mid-stream reset.
module tb_global_buffer;
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PRST  = 4'd1;
    localparam logic [3:0] OP_LDW   = 4'd2;
    localparam logic [3:0] OP_LDA   = 4'd3;
    localparam logic [3:0] OP_LDO   = 4'd4;
    localparam logic [3:0] OP_READ  = 4'd5;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    global_buffer_if bus ();

    global_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] wword(input int i);
        return {4{32'hC0DE0000 + 32'(i)}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] waddr,
                         input logic [31:0] aaddr, input logic [8:0] cnt);
        bus.instr                 = op;
        bus.weight_start_addr     = waddr;
        bus.activation_start_addr = aaddr;
        bus.read_count            = cnt;
        bus.instr_valid           = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        bus.instr       = OP_NOP;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.instr = OP_NOP; bus.instr_valid = 1'b0; bus.weight_start_addr = '0;
        bus.activation_start_addr = '0; bus.read_count = '0; bus.wr_data = '0; bus.wr_en = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.instr_ready); end
        checks++; if (bus.rd_data !== 128'd0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
        checks++; if (bus.rd_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.rd_data_valid); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.wr_drop !== 1'b0) begin failures++; $display("FAIL reset_wr_drop: got %b expected 0", bus.wr_drop); end
        issue(4'd9, 32'h0, 32'h0, 9'd0);
        step();
        checks++; if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0 || bus.wr_drop !== 1'b0 || bus.rd_data_valid !== 1'b0)
            begin failures++; $display("FAIL illegal_op: ready=%b done=%b drop=%b valid=%b expected 1 0 0 0",
                bus.instr_ready, bus.done, bus.wr_drop, bus.rd_data_valid); end
    endtask

    task automatic test_load_read();
        issue(OP_LDA, 32'h0, 32'h10, 9'd0);
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 128'(32'hA0 + 32'(i));
            step();
        end
        bus.wr_en = 1'b0;
        issue(OP_READ, 32'h0, 32'h10, 9'd4);
        checks++; if (bus.instr_ready !== 1'b0 || bus.rd_data_valid !== 1'b0)
            begin failures++; $display("FAIL read_c1: ready=%b valid=%b expected 0 0", bus.instr_ready, bus.rd_data_valid); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus.rd_data !== 128'(32'hA0 + 32'(k)) || bus.rd_data_valid !== 1'b1)
                begin failures++; $display("FAIL read_word%0d: got %h valid=%b expected %h valid=1", k, bus.rd_data, bus.rd_data_valid, 128'(32'hA0 + 32'(k))); end
            checks++; if (bus.done !== (k == 3) || bus.instr_ready !== 1'b0)
                begin failures++; $display("FAIL read_ctl%0d: done=%b ready=%b expected %b 0", k, bus.done, bus.instr_ready, (k == 3)); end
        end
        step();
        checks++; if (bus.rd_data_valid !== 1'b0 || bus.done !== 1'b0 || bus.instr_ready !== 1'b1)
            begin failures++; $display("FAIL read_end: valid=%b done=%b ready=%b expected 0 0 1", bus.rd_data_valid, bus.done, bus.instr_ready); end
        checks++; if (bus.rd_data !== 128'hA3)
            begin failures++; $display("FAIL read_hold: got %h expected a3", bus.rd_data); end
    endtask

    task automatic test_wrap();
        issue(OP_LDW, 32'h1FE, 32'h0, 9'd0);
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = wword(i);
            step();
        end
        bus.wr_en = 1'b0;
        issue(OP_READ, 32'h0, 32'd254, 9'd4);
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus.rd_data !== wword(k) || bus.rd_data_valid !== 1'b1)
                begin failures++; $display("FAIL wrap_word%0d: got %h expected %h", k, bus.rd_data, wword(k)); end
        end
        step();
        issue(OP_READ, 32'h0, 32'd0, 9'd1);
        step();
        checks++; if (bus.rd_data !== wword(2) || bus.done !== 1'b1)
            begin failures++; $display("FAIL wrap_addr0: got %h done=%b expected %h done=1", bus.rd_data, bus.done, wword(2)); end
        step();
    endtask

    task automatic test_load_output();
        issue(OP_LDA, 32'h0, 32'h20, 9'd0);
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 128'(32'hC0 + 32'(i));
            step();
        end
        bus.wr_en = 1'b0;
        issue(OP_LDO, 32'h0, 32'h0, 9'd0);
        bus.wr_en = 1'b1; bus.wr_data = 128'h00C3;
        step();
        bus.wr_en = 1'b0;
        issue(OP_READ, 32'h0, 32'h20, 9'd4);
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus.rd_data !== 128'(32'hC0 + 32'(k)))
                begin failures++; $display("FAIL append_word%0d: got %h expected %h", k, bus.rd_data, 128'(32'hC0 + 32'(k))); end
        end
        step();
        issue(OP_PRST, 32'h0, 32'h0, 9'd0);
        issue(OP_LDO, 32'h0, 32'h0, 9'd0);
        bus.wr_en = 1'b1; bus.wr_data = 128'h00D0;
        step();
        bus.wr_en = 1'b0;
        issue(OP_READ, 32'h0, 32'h0, 9'd1);
        step();
        checks++; if (bus.rd_data !== 128'h00D0 || bus.rd_data_valid !== 1'b1)
            begin failures++; $display("FAIL prst_append: got %h expected d0", bus.rd_data); end
        step();
    endtask

    task automatic test_drops();
        // IDLE drop; wr_ptr currently 1 which holds wword(3)
        bus.wr_en = 1'b1; bus.wr_data = 128'h00EE;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.wr_drop !== 1'b1) begin failures++; $display("FAIL drop_idle: got %b expected 1", bus.wr_drop); end
        step();
        checks++; if (bus.wr_drop !== 1'b0) begin failures++; $display("FAIL drop_pulse: got %b expected 0", bus.wr_drop); end
        // drop during READ
        issue(OP_READ, 32'h0, 32'h20, 9'd2);
        bus.wr_en = 1'b1; bus.wr_data = 128'h00FF;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.wr_drop !== 1'b1 || bus.rd_data !== 128'h00C0)
            begin failures++; $display("FAIL drop_read: drop=%b data=%h expected 1 c0", bus.wr_drop, bus.rd_data); end
        step();
        checks++; if (bus.rd_data !== 128'h00C1 || bus.done !== 1'b1)
            begin failures++; $display("FAIL drop_read_tail: data=%h done=%b expected c1 1", bus.rd_data, bus.done); end
        step();
        // drop on the LOAD accept cycle
        bus.wr_en = 1'b1; bus.wr_data = 128'h0077;
        issue(OP_LDA, 32'h0, 32'h21, 9'd0);
        bus.wr_en = 1'b0;
        checks++; if (bus.wr_drop !== 1'b1) begin failures++; $display("FAIL drop_accept: got %b expected 1", bus.wr_drop); end
        issue(OP_PRST, 32'h0, 32'h0, 9'd0);
        issue(OP_READ, 32'h0, 32'h21, 9'd1);
        step();
        checks++; if (bus.rd_data !== 128'h00C1)
            begin failures++; $display("FAIL drop_accept_mem: got %h expected c1", bus.rd_data); end
        step();
        issue(OP_READ, 32'h0, 32'h1, 9'd1);
        step();
        checks++; if (bus.rd_data !== wword(3))
            begin failures++; $display("FAIL drop_idle_mem: got %h expected %h", bus.rd_data, wword(3)); end
        step();
        // zero-length read
        issue(OP_READ, 32'h0, 32'h20, 9'd0);
        checks++; if (bus.done !== 1'b1 || bus.rd_data_valid !== 1'b0 || bus.instr_ready !== 1'b1)
            begin failures++; $display("FAIL read_zero: done=%b valid=%b ready=%b expected 1 0 1", bus.done, bus.rd_data_valid, bus.instr_ready); end
        step();
        checks++; if (bus.done !== 1'b0 || bus.rd_data_valid !== 1'b0)
            begin failures++; $display("FAIL read_zero_after: done=%b valid=%b expected 0 0", bus.done, bus.rd_data_valid); end
    endtask

    task automatic test_reset_mid_read();
        issue(OP_READ, 32'h0, 32'h20, 9'd8);
        step(); step();
        checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== 128'h00C1)
            begin failures++; $display("FAIL midrst_pre: valid=%b data=%h expected 1 c1", bus.rd_data_valid, bus.rd_data); end
        rst = 1'b1;
        #1;
        checks++; if (bus.rd_data_valid !== 1'b0 || bus.done !== 1'b0 || bus.instr_ready !== 1'b1)
            begin failures++; $display("FAIL midrst_outs: valid=%b done=%b ready=%b expected 0 0 1", bus.rd_data_valid, bus.done, bus.instr_ready); end
        checks++; if (dut.wr_ptr !== 8'd0 || dut.rd_ptr !== 8'd0)
            begin failures++; $display("FAIL midrst_ptrs: wr=%h rd=%h expected 0 0", dut.wr_ptr, dut.rd_ptr); end
        #2;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (bus.rd_data_valid !== 1'b0 || bus.done !== 1'b0)
                begin failures++; $display("FAIL midrst_quiet%0d: valid=%b done=%b expected 0 0", k, bus.rd_data_valid, bus.done); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load_read();
        test_wrap();
        test_load_output();
        test_drops();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
